// File: rtl/scratchpad_pkg.sv
// Shared encodings for the scratchpad array: request opcodes and sequencer states.
package scratchpad_pkg;

    localparam logic [1:0] RD  = 2'd0;
    localparam logic [1:0] WR  = 2'd1;
    localparam logic [1:0] XCH = 2'd2;
    localparam logic [1:0] INC = 2'd3;

    typedef enum logic [1:0] {
        OP_RD  = RD,
        OP_WR  = WR,
        OP_XCH = XCH,
        OP_INC = INC
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRECH,
        ST_READ,
        ST_MOD,
        ST_WB
    } state_t;

    // RD and XCH report the value found before the update; WR and INC report the new one.
    function automatic logic op_returns_old(op_t op);
        return (op == OP_RD) || (op == OP_XCH);
    endfunction

endpackage

// File: rtl/scratchpad_array_gen_if.sv
// Request/response bundle between a scratchpad client (master) and the array (slave).
interface scratchpad_array_gen_if #(
    parameter int ROWS   = 8,
    parameter int COLS   = 2,
    parameter int DATA_W = 4
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [RW-1:0]     req_row;
    logic [CW-1:0]     req_col;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_carry;

    modport master (
        output req_valid, req_op, req_row, req_col, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_carry
    );

    modport slave (
        input  req_valid, req_op, req_row, req_col, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_carry
    );

endinterface

// File: rtl/scratchpad_rfsh_ctl.sv
// Refresh scheduler: free-running interval counter, pending flag and next-row pointer.
// Pending is raised on terminal count, cleared by start; row advances on done.
module scratchpad_rfsh_ctl #(
    parameter int ROWS          = 8,
    parameter int RFSH_INTERVAL = 16,
    localparam int RW    = $clog2(ROWS),
    localparam int CNT_W = $clog2(RFSH_INTERVAL)
) (
    input  logic          sysclk,
    input  logic          poc_n,
    input  logic          start,
    input  logic          done,
    output logic          pending,
    output logic [RW-1:0] row
);

    logic [CNT_W-1:0] cnt;
    logic             tc;

    assign tc = (cnt == CNT_W'(RFSH_INTERVAL - 1));

    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            cnt     <= '0;
            pending <= 1'b0;
            row     <= '0;
        end else begin
            cnt <= tc ? '0 : cnt + 1'b1;
            // A terminal count while already pending just leaves the flag set.
            if (tc)
                pending <= 1'b1;
            else if (start)
                pending <= 1'b0;
            if (done)
                row <= row + 1'b1;
        end
    end

endmodule

// File: rtl/scratchpad_array_gen.sv
// ROWS x COLS scratchpad register file with row-buffer RMW sequencing and autonomous refresh.
// Latency: request accepted at edge k -> write-back and rsp_valid at edge k+4; one request per 5 cycles.
// req_ready only in IDLE with no refresh pending. SCRATCHPAD_DECAY_EN adds per-row decay ageing.
module scratchpad_array_gen
    import scratchpad_pkg::*;
#(
    parameter int ROWS          = 8,
    parameter int COLS          = 2,
    parameter int DATA_W        = 4,
`ifdef SCRATCHPAD_DECAY_EN
    parameter int DECAY_LIMIT   = 256,
`endif
    parameter int RFSH_INTERVAL = 16,
    localparam int RW     = $clog2(ROWS),
    localparam int CW     = $clog2(COLS),
    localparam int LINE_W = COLS * DATA_W
) (
    input  logic                 sysclk,
    input  logic                 poc_n,
    scratchpad_array_gen_if.slave bus,
    output logic                 rfsh_busy,
    output logic [RW-1:0]        rfsh_row
);

    state_t state, state_nxt;

    logic              is_rfsh;
    op_t               op_q;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] line_mod;
    logic [LINE_W-1:0] arr_line;
    logic [DATA_W-1:0] old_fld;
    logic [DATA_W-1:0] new_fld;
    logic [DATA_W-1:0] rsp_fld;
    logic              carry_nxt;
    logic [DATA_W-1:0] rsp_dat_q;
    logic              carry_q;

    logic accept;
    logic rfsh_start;
    logic rfsh_done;
    logic rfsh_pending;
    logic wb_en;
    logic req_ready;

    logic [LINE_W-1:0] mem [ROWS];

    scratchpad_rfsh_ctl #(
        .ROWS          (ROWS),
        .RFSH_INTERVAL (RFSH_INTERVAL)
    ) u_rfsh_ctl (
        .sysclk  (sysclk),
        .poc_n   (poc_n),
        .start   (rfsh_start),
        .done    (rfsh_done),
        .pending (rfsh_pending),
        .row     (rfsh_row)
    );

    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        rfsh_start = 1'b0;
        rfsh_done  = 1'b0;
        wb_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                // Refresh takes priority over a request presented in the same cycle.
                if (rfsh_pending) begin
                    rfsh_start = 1'b1;
                    state_nxt  = ST_PRECH;
                end else begin
                    req_ready = 1'b1;
                    if (bus.req_valid) begin
                        accept    = 1'b1;
                        state_nxt = ST_PRECH;
                    end
                end
            end
            ST_PRECH: state_nxt = ST_READ;
            ST_READ:  state_nxt = is_rfsh ? ST_WB : ST_MOD;
            ST_MOD:   state_nxt = ST_WB;
            ST_WB: begin
                wb_en     = 1'b1;
                rfsh_done = is_rfsh;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready = req_ready;
    assign rfsh_busy     = is_rfsh && (state != ST_IDLE);

    // Column 0 sits in the most significant field of the row word.
    always_comb begin
        old_fld = '0;
        for (int c = 0; c < COLS; c++)
            if (col_q == CW'(c))
                old_fld = line_buf[(COLS-1-c)*DATA_W +: DATA_W];

        new_fld = old_fld;
        case (op_q)
            OP_WR, OP_XCH: new_fld = wdata_q;
            OP_INC:        new_fld = old_fld + 1'b1;
            default:       new_fld = old_fld;
        endcase

        rsp_fld   = op_returns_old(op_q) ? old_fld : new_fld;
        carry_nxt = (op_q == OP_INC) && (&old_fld);

        line_mod = line_buf;
        for (int c = 0; c < COLS; c++)
            if (col_q == CW'(c))
                line_mod[(COLS-1-c)*DATA_W +: DATA_W] = new_fld;
    end

    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            is_rfsh       <= 1'b0;
            op_q          <= OP_RD;
            row_q         <= '0;
            col_q         <= '0;
            wdata_q       <= '0;
            line_buf      <= '0;
            rsp_dat_q     <= '0;
            carry_q       <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_carry <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            if (accept) begin
                is_rfsh <= 1'b0;
                op_q    <= op_t'(bus.req_op);
                row_q   <= bus.req_row;
                col_q   <= bus.req_col;
                wdata_q <= bus.req_wdata;
            end else if (rfsh_start) begin
                is_rfsh <= 1'b1;
                row_q   <= rfsh_row;
            end
            case (state)
                ST_PRECH: line_buf <= '0;
                ST_READ:  line_buf <= arr_line;
                ST_MOD: begin
                    line_buf  <= line_mod;
                    rsp_dat_q <= rsp_fld;
                    carry_q   <= carry_nxt;
                end
                ST_WB: begin
                    if (!is_rfsh) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= rsp_dat_q;
                        bus.rsp_carry <= carry_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset; an abandoned operation never reaches WB, so nothing is written.
    always_ff @(posedge sysclk) begin
        if (wb_en)
            mem[row_q] <= line_buf;
    end

`ifdef SCRATCHPAD_DECAY_EN
    localparam int AGE_W = $clog2(DECAY_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(DECAY_LIMIT);

    logic [AGE_W-1:0] age [ROWS];

    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            for (int r = 0; r < ROWS; r++)
                age[r] <= AGE_MAX;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (wb_en && (row_q == RW'(r)))
                    age[r] <= '0;
                else if (age[r] != AGE_MAX)
                    age[r] <= age[r] + 1'b1;
            end
        end
    end

    assign arr_line = (age[row_q] == AGE_MAX) ? '0 : mem[row_q];
`else
    assign arr_line = mem[row_q];
`endif

endmodule
